// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX (and future RX) datapaths.
// Latency: none, declarations only.
// Backpressure: not applicable.
package uart_pkg;

  // Frame sequencer states, in transmission order
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Parity selection values for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Total serial bits in one frame: start + data + optional parity + stops
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_param_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last count of each bit.
// Latency: tick is combinational from the registered count; restart takes effect next edge.
// Backpressure: none, free-running unless restarted.
module baud_gen #(
  parameter int CLKS_PER_BIT = 414
) (
  input  logic CLKIN,
  input  logic RESET,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("baud_gen: CLKS_PER_BIT must be 2 or more");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart forces zero, otherwise wrap from the last count back to zero
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits.
// Latency: out/busy change one clock after the handshake edge; a frame spans F*CLKS_PER_BIT clocks.
// Backpressure: ready only in IDLE or the final stop-bit cycle, so back-to-back frames have no gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 414,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLKIN,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 out,
  output logic                 busy
);

  // Bit index covers the longest run inside a frame (data bits or stop bits)
  localparam int IDX_W = $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS));
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be 2 or more");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if ((PARITY != PAR_NONE) && (PARITY != PAR_ODD) && (PARITY != PAR_EVEN)) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_sb
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;

  logic tick;
  logic last_stop;
  logic hs;
  logic baud_restart;
  logic word_par;

  // Parity of the incoming word, computed at the handshake so later data changes cannot leak in
  assign word_par = (PARITY == PAR_ODD) ? ~(^data) : (^data);

  // Final clock of the final stop bit: the only mid-frame slot where a new word may be taken
  assign last_stop = (state_q == STOP) && tick && (bit_q == STOP_LAST);

  // ready depends on state and counters only; valid never feeds back into it
  assign ready = !RESET && ((state_q == IDLE) || last_stop);
  assign hs    = valid && ready;

  // Hold the bit timer at zero while idle so every frame starts with a full bit period
  assign baud_restart = hs || (state_q == IDLE);

  baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .CLKIN   (CLKIN),
    .RESET   (RESET),
    .restart (baud_restart),
    .tick    (tick)
  );

  // Frame sequencer next state: advance one bit per tick, reload on handshake
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    par_d   = par_q;

    unique case (state_q)
      IDLE: begin
        // reload handled below
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A handshake (idle or last stop cycle) latches the word and begins a new frame
    if (hs) begin
      shreg_d = data;
      par_d   = word_par;
      bit_d   = '0;
      state_d = START;
    end
  end

  // Line level and busy flag derived from the current state, registered for a glitch-free pin
  always_comb begin
    out_d  = 1'b1;
    busy_d = (state_q != IDLE);
    unique case (state_q)
      IDLE:    out_d = 1'b1;
      START:   out_d = 1'b0;
      DATA:    out_d = shreg_q[0];
      PAR:     out_d = par_q;
      STOP:    out_d = 1'b1;
      default: out_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and discards the partial word
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param across four parameter sets sharing one clock and reset.
// Latency: checks every clock of each frame, sampled 1 time unit after the rising edge.
// Backpressure: producers wait for ready before presenting a word.
module tb_uart_tx_param;

  logic       CLKIN = 1'b0;
  logic       RESET;
  logic [3:0] vld_r;
  logic [7:0] dat_r [4];
  logic [3:0] rdy_w;
  logic [3:0] out_w;
  logic [3:0] busy_w;

  int checks   = 0;
  int failures = 0;

  always #5 CLKIN = ~CLKIN;

  // 0: defaults (414 clk/bit, 8N1)
  uart_tx_param u_a (
    .CLKIN (CLKIN), .RESET (RESET), .data (dat_r[0]), .valid (vld_r[0]),
    .ready (rdy_w[0]), .out (out_w[0]), .busy (busy_w[0])
  );

  // 1: 4 clk/bit, 8 data, even parity, 1 stop
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .CLKIN (CLKIN), .RESET (RESET), .data (dat_r[1]), .valid (vld_r[1]),
    .ready (rdy_w[1]), .out (out_w[1]), .busy (busy_w[1])
  );

  // 2: 4 clk/bit, 5 data, odd parity, 2 stop
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u_c (
    .CLKIN (CLKIN), .RESET (RESET), .data (dat_r[2][4:0]), .valid (vld_r[2]),
    .ready (rdy_w[2]), .out (out_w[2]), .busy (busy_w[2])
  );

  // 3: 2 clk/bit, 8N1
  uart_tx_param #(.CLKS_PER_BIT(2)) u_d (
    .CLKIN (CLKIN), .RESET (RESET), .data (dat_r[3]), .valid (vld_r[3]),
    .ready (rdy_w[3]), .out (out_w[3]), .busy (busy_w[3])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    while ((rdy_w[idx] !== 1'b1) && (n < 20000)) begin
      @(posedge CLKIN);
      #1;
      n++;
    end
    check($sformatf("ready_wait_u%0d", idx), 16'(rdy_w[idx]), 16'd1);
  endtask

  // Sends (or continues) one frame and checks out/busy/ready on every clock.
  // bits holds the expected line level per frame bit, index 0 = start bit.
  task automatic run_frame(input int idx, input int n, input int nbits, input logic [15:0] bits,
                           input logic [7:0] word, input bit at_t, input bit keep_vld,
                           input logic [7:0] next_word, input bit b2b, input bit toggle);
    logic rexp;
    if (!at_t) begin
      vld_r[idx] = 1'b1;
      dat_r[idx] = word;
      @(posedge CLKIN);
      #1;
    end
    vld_r[idx] = keep_vld;
    dat_r[idx] = next_word;
    for (int c = 1; c <= nbits * n; c++) begin
      @(posedge CLKIN);
      #1;
      if (toggle) begin
        dat_r[idx] = 8'($urandom);
        vld_r[idx] = (c < nbits * n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      rexp = (c == nbits * n - 1) || ((c == nbits * n) && !b2b);
      check($sformatf("out_u%0d_c%0d", idx, c), 16'(out_w[idx]), 16'(bits[(c - 1) / n]));
      check($sformatf("busy_u%0d_c%0d", idx, c), 16'(busy_w[idx]), 16'd1);
      check($sformatf("ready_u%0d_c%0d", idx, c), 16'(rdy_w[idx]), 16'(rexp));
    end
    if (!b2b) begin
      @(posedge CLKIN);
      #1;
      check($sformatf("end_busy_u%0d", idx), 16'(busy_w[idx]), 16'd0);
      check($sformatf("end_out_u%0d", idx), 16'(out_w[idx]), 16'd1);
      check($sformatf("end_ready_u%0d", idx), 16'(rdy_w[idx]), 16'd1);
    end
  endtask

  initial begin
    RESET = 1'b1;
    vld_r = '0;
    for (int i = 0; i < 4; i++) dat_r[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge CLKIN);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_out_u%0d", i), 16'(out_w[i]), 16'd1);
      check($sformatf("rst_busy_u%0d", i), 16'(busy_w[i]), 16'd0);
      check($sformatf("rst_ready_u%0d", i), 16'(rdy_w[i]), 16'd0);
    end
    RESET = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_rst_ready_u%0d", i), 16'(rdy_w[i]), 16'd1);
    end

    // Defaults, 0x55: 0,1,0,1,0,1,0,1,0,1 at 414 clocks per bit
    wait_ready(0);
    run_frame(0, 414, 10, 16'h02AA, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 4 clk/bit even parity, 0x07: 0,1,1,1,0,0,0,0,0,1,1
    wait_ready(1);
    run_frame(1, 4, 11, 16'h060E, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 4 clk/bit, 5 data, odd parity, 2 stop, 0x1F: 0,1,1,1,1,1,0,1,1
    wait_ready(2);
    run_frame(2, 4, 9, 16'h01BE, 8'h1F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back 0xA5 then 0x3C with valid held high, 2 clk/bit
    wait_ready(3);
    run_frame(3, 2, 10, 16'h034A, 8'hA5, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    run_frame(3, 2, 10, 16'h0278, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset pulse mid-frame, then a clean 0x81 frame (even parity bit 0)
    wait_ready(1);
    vld_r[1] = 1'b1;
    dat_r[1] = 8'h00;
    @(posedge CLKIN);
    #1;
    vld_r[1] = 1'b0;
    repeat (9) begin
      @(posedge CLKIN);
      #1;
    end
    check("midframe_out", 16'(out_w[1]), 16'd0);
    check("midframe_busy", 16'(busy_w[1]), 16'd1);
    RESET = 1'b1;
    #1;
    check("reset_forces_ready_low", 16'(rdy_w[1]), 16'd0);
    @(posedge CLKIN);
    #1;
    check("abort_out", 16'(out_w[1]), 16'd1);
    check("abort_busy", 16'(busy_w[1]), 16'd0);
    RESET = 1'b0;
    #1;
    check("abort_ready_after_release", 16'(rdy_w[1]), 16'd1);
    run_frame(1, 4, 11, 16'h0502, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Data and valid wiggling mid-frame must not disturb the latched 0xC3
    wait_ready(1);
    run_frame(1, 4, 11, 16'h0586, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
